// File: rtl/spram_fifo_ctrl.sv
// Turns one single-port SRAM (1-cycle read latency) into a first-word-fall-through FIFO.
// Each cycle one access is granted: commit the staged write word or prefetch into a 2-entry output buffer.
module spram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH+4)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [CNT_WIDTH-1:0]  o_count
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FIFO_DEPTH-1);
  localparam logic [CNT_WIDTH-1:0]  DEPTH_C   = CNT_WIDTH'(FIFO_DEPTH);

  logic                  r_stg_valid;
  logic [DATA_WIDTH-1:0] r_stg_data;
  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [CNT_WIDTH-1:0]  r_mem_count, r_count;
  logic [DATA_WIDTH-1:0] r_ob0, r_ob1;
  logic [1:0]            r_occ;
  logic                  r_inflight, r_last_rd;

  logic                  w_wr_req, w_rd_req, w_wr_grant, w_rd_grant, w_push, w_pop;
  logic                  w_stg_valid_nx;
  logic [CNT_WIDTH-1:0]  w_mem_count_nx;
  logic [DATA_WIDTH-1:0] w_ob0_nx, w_ob1_nx;
  logic [1:0]            w_occ_nx;

  // Read request counts the in-flight word so the buffer can never be overrun.
  assign w_wr_req   = r_stg_valid && (r_mem_count < DEPTH_C);
  assign w_rd_req   = (r_mem_count != '0) &&
                      ((r_occ == 2'd0) || ((r_occ == 2'd1) && !r_inflight));
  assign w_wr_grant = w_wr_req && (!w_rd_req || r_last_rd);
  assign w_rd_grant = w_rd_req && (!w_wr_req || !r_last_rd);

  assign o_wr_ready  = !r_stg_valid || w_wr_grant;
  assign o_rd_valid  = (r_occ != 2'd0);
  assign o_rd_data   = r_ob0;
  assign o_mem_en    = w_wr_grant || w_rd_grant;
  assign o_mem_we    = w_wr_grant;
  assign o_mem_addr  = w_wr_grant ? r_wptr : r_rptr;
  assign o_mem_wdata = r_stg_data;
  assign o_count     = r_count;

  assign w_push         = i_wr_valid && o_wr_ready;
  assign w_pop          = o_rd_valid && i_rd_ready;
  assign w_stg_valid_nx = w_push || (r_stg_valid && !w_wr_grant);
  assign w_mem_count_nx = r_mem_count + CNT_WIDTH'(w_wr_grant) - CNT_WIDTH'(w_rd_grant);

  // Output buffer: ob0 is the head; returning SRAM data lands behind any held word.
  always_comb begin
    w_ob0_nx = r_ob0;
    w_ob1_nx = r_ob1;
    w_occ_nx = r_occ;
    case ({r_inflight, w_pop})
      2'b10: begin
        if (r_occ == 2'd0) w_ob0_nx = i_mem_rdata;
        else               w_ob1_nx = i_mem_rdata;
        w_occ_nx = r_occ + 2'd1;
      end
      2'b01: begin
        w_ob0_nx = r_ob1;
        w_occ_nx = r_occ - 2'd1;
      end
      2'b11: begin
        if (r_occ == 2'd1) w_ob0_nx = i_mem_rdata;
        else begin
          w_ob0_nx = r_ob1;
          w_ob1_nx = i_mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stg_valid <= 1'b0;
      r_stg_data  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_mem_count <= '0;
      r_ob0       <= '0;
      r_ob1       <= '0;
      r_occ       <= 2'd0;
      r_inflight  <= 1'b0;
      r_last_rd   <= 1'b1;
      r_count     <= '0;
    end else begin
      r_stg_valid <= w_stg_valid_nx;
      if (w_push) r_stg_data <= i_wr_data;
      if (w_wr_grant) r_wptr <= (r_wptr == LAST_ADDR) ? '0 : r_wptr + ADDR_WIDTH'(1);
      if (w_rd_grant) r_rptr <= (r_rptr == LAST_ADDR) ? '0 : r_rptr + ADDR_WIDTH'(1);
      if (w_wr_grant || w_rd_grant) r_last_rd <= w_rd_grant;
      r_mem_count <= w_mem_count_nx;
      r_ob0       <= w_ob0_nx;
      r_ob1       <= w_ob1_nx;
      r_occ       <= w_occ_nx;
      r_inflight  <= w_rd_grant;
      r_count     <= w_mem_count_nx + CNT_WIDTH'(w_stg_valid_nx) +
                     CNT_WIDTH'(w_occ_nx) + CNT_WIDTH'(w_rd_grant);
    end
  end
endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Directed bench for spram_fifo_ctrl: a depth-32 instance for latency/full/throughput/reset,
// and a depth-5 instance for pointer wrap under random consumer back-pressure.
module tb_spram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready, a_mem_en, a_mem_we;
  logic [7:0] a_wr_data, a_rd_data, a_mem_wdata, a_mem_rdata;
  logic [4:0] a_mem_addr;
  logic [5:0] a_count;

  logic       b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_mem_en, b_mem_we;
  logic [7:0] b_wr_data, b_rd_data, b_mem_wdata, b_mem_rdata;
  logic [2:0] b_mem_addr;
  logic [3:0] b_count;

  spram_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(32)) u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(a_wr_valid), .i_wr_data(a_wr_data), .o_wr_ready(a_wr_ready),
    .o_rd_valid(a_rd_valid), .o_rd_data(a_rd_data), .i_rd_ready(a_rd_ready),
    .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
    .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata), .o_count(a_count));

  spram_fifo_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(5)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_valid(b_wr_valid), .i_wr_data(b_wr_data), .o_wr_ready(b_wr_ready),
    .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data), .i_rd_ready(b_rd_ready),
    .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata), .o_count(b_count));

  // Behavioural single-port SRAMs with 1-cycle read latency.
  logic [7:0] a_ram [32];
  logic [7:0] b_ram [8];
  always_ff @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) a_ram[a_mem_addr] <= a_mem_wdata;
      else          a_mem_rdata <= a_ram[a_mem_addr];
    end
    if (b_mem_en) begin
      if (b_mem_we) b_ram[b_mem_addr] <= b_mem_wdata;
      else          b_mem_rdata <= b_ram[b_mem_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  initial begin
    int  nxt, exp_rd, npush, npop, wa, ra, nwr;
    logic prev_we, got;

    rst_n = 1'b0;
    a_wr_valid = 0; a_wr_data = 0; a_rd_ready = 0;
    b_wr_valid = 0; b_wr_data = 0; b_rd_ready = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    mid();
    chk("rst_wr_ready", a_wr_ready, 1);
    chk("rst_rd_valid", a_rd_valid, 0);
    chk("rst_count", a_count, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_mem_we", a_mem_we, 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_mem_wdata", a_mem_wdata, 0);
    chk("rst_rd_data", a_rd_data, 0);
    tick();

    // Single word latency
    a_wr_valid = 1; a_wr_data = 8'hA5; a_rd_ready = 1;
    mid(); chk("lat_c0_wr_ready", a_wr_ready, 1); tick();
    a_wr_valid = 0;
    mid();
    chk("lat_c1_mem_en", a_mem_en, 1);
    chk("lat_c1_mem_we", a_mem_we, 1);
    chk("lat_c1_addr", a_mem_addr, 0);
    chk("lat_c1_wdata", a_mem_wdata, 8'hA5);
    chk("lat_c1_count", a_count, 1);
    tick(); mid();
    chk("lat_c2_mem_en", a_mem_en, 1);
    chk("lat_c2_mem_we", a_mem_we, 0);
    chk("lat_c2_addr", a_mem_addr, 0);
    tick(); mid();
    chk("lat_c3_mem_en", a_mem_en, 0);
    chk("lat_c3_rd_valid", a_rd_valid, 0);
    chk("lat_c3_count", a_count, 1);
    tick(); mid();
    chk("lat_c4_rd_valid", a_rd_valid, 1);
    chk("lat_c4_rd_data", a_rd_data, 8'hA5);
    chk("lat_c4_count", a_count, 1);
    tick(); mid();
    chk("lat_c5_rd_valid", a_rd_valid, 0);
    chk("lat_c5_count", a_count, 0);
    tick();

    // Pop while empty: ignored, no SRAM access
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("empty_mem_en", a_mem_en, 0);
      chk("empty_count", a_count, 0);
      tick();
    end

    // Fill: offer 0..40 with consumer stalled
    a_rd_ready = 0; nxt = 0;
    for (int k = 0; k < 100; k++) begin
      a_wr_valid = (nxt < 41); a_wr_data = nxt[7:0];
      mid();
      if (a_wr_valid && a_wr_ready) nxt++;
      tick();
    end
    a_wr_valid = 1; a_wr_data = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("full_accepted", nxt, 35);
      chk("full_wr_ready", a_wr_ready, 0);
      chk("full_count", a_count, 35);
      chk("full_mem_en", a_mem_en, 0);
      chk("full_head", a_rd_data, 0);
      tick();
    end
    a_wr_valid = 0; a_rd_ready = 1; exp_rd = 0;
    for (int k = 0; k < 200 && exp_rd < 35; k++) begin
      mid();
      if (a_rd_valid) begin
        chk("drain_data", a_rd_data, exp_rd);
        exp_rd++;
      end
      tick();
    end
    chk("drain_total", exp_rd, 35);
    mid();
    chk("drain_count", a_count, 0);
    chk("drain_rd_valid", a_rd_valid, 0);
    tick();

    // Sustained read+write after a 4-word prefill
    a_rd_ready = 0; nxt = 100;
    for (int k = 0; k < 20 && nxt < 104; k++) begin
      a_wr_valid = 1; a_wr_data = nxt[7:0];
      mid();
      if (a_wr_ready) nxt++;
      tick();
    end
    a_wr_valid = 0;
    repeat (6) tick();
    exp_rd = 100; npush = 0; npop = 0; prev_we = 0;
    for (int k = 0; k < 42; k++) begin
      a_wr_valid = 1; a_wr_data = nxt[7:0]; a_rd_ready = 1;
      mid();
      if (k >= 1) chk("sus_mem_en", a_mem_en, 1);
      if (k >= 2) chk("sus_we_toggle", a_mem_we, !prev_we);
      prev_we = a_mem_we;
      if (a_rd_valid) begin
        chk("sus_data", a_rd_data, exp_rd[7:0]);
        exp_rd++;
        if (k >= 2) npop++;
      end
      if (a_wr_ready) begin
        nxt++;
        if (k >= 2) npush++;
      end
      tick();
    end
    chk("sus_push_rate", npush, 20);
    chk("sus_pop_rate", npop, 20);
    a_wr_valid = 0;
    for (int k = 0; k < 100 && exp_rd < nxt; k++) begin
      mid();
      if (a_rd_valid) begin
        chk("sus_drain_data", a_rd_data, exp_rd[7:0]);
        exp_rd++;
      end
      tick();
    end
    chk("sus_drain_total", exp_rd, nxt);
    mid(); chk("sus_drain_count", a_count, 0); tick();

    // Reset mid-operation with 10 words held
    a_rd_ready = 0; nxt = 50;
    for (int k = 0; k < 40 && nxt < 60; k++) begin
      a_wr_valid = 1; a_wr_data = nxt[7:0];
      mid();
      if (a_wr_ready) nxt++;
      tick();
    end
    a_wr_valid = 0;
    repeat (4) tick();
    mid(); chk("mrst_pre_count", a_count, 10); tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    mid();
    chk("mrst_count", a_count, 0);
    chk("mrst_rd_valid", a_rd_valid, 0);
    chk("mrst_wr_ready", a_wr_ready, 1);
    chk("mrst_mem_en", a_mem_en, 0);
    tick();
    a_wr_valid = 1; a_wr_data = 8'h3C; a_rd_ready = 1;
    tick();
    a_wr_valid = 0; got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      mid();
      if (a_rd_valid) begin
        got = 1;
        chk("mrst_first_data", a_rd_data, 8'h3C);
      end
      tick();
    end
    chk("mrst_seen", got, 1);

    // Depth-5 wrap with random back-pressure
    nxt = 0; exp_rd = 0; wa = 0; ra = 0; nwr = 0;
    for (int k = 0; k < 400 && exp_rd < 20; k++) begin
      b_wr_valid = (nxt < 20); b_wr_data = nxt[7:0] + 8'h40;
      b_rd_ready = 1'($urandom_range(0, 1));
      mid();
      chk("wrap_count_max", b_count <= 4'd8, 1);
      if (b_mem_en && b_mem_we) begin
        chk("wrap_waddr", b_mem_addr, wa);
        wa = (wa + 1) % 5; nwr++;
      end
      if (b_mem_en && !b_mem_we) begin
        chk("wrap_raddr", b_mem_addr, ra);
        ra = (ra + 1) % 5;
      end
      if (b_rd_valid && b_rd_ready) begin
        chk("wrap_data", b_rd_data, exp_rd + 8'h40);
        exp_rd++;
      end
      if (b_wr_valid && b_wr_ready) nxt++;
      tick();
    end
    b_wr_valid = 0; b_rd_ready = 0;
    chk("wrap_total", exp_rd, 20);
    chk("wrap_writes", nwr, 20);
    mid(); chk("wrap_count_end", b_count, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
